// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the stream round-robin arbiter.
package stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int NB_DEF = 80;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Packet counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted req after index 'last', wrapping modulo N_IN.
module rr_pick #(
  parameter int N_IN  = 4,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester after 'last' wins.
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = N_IN; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % N_IN);
      if (req[cand]) begin
        idx     = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter of N_IN streams into one registered output stream.
// Optional per-input packet counters are enabled with `define STREAM_RR_ARBITER_STATS_EN.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int NB   = NB_DEF
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_IN*NB-1:0]        in_tdata,
  input  logic [N_IN-1:0]           in_tvalid,
  input  logic [N_IN-1:0]           in_tlast,
  output logic [N_IN-1:0]           in_tready,
  output logic [NB-1:0]             out_tdata,
  output logic                      out_tvalid,
  output logic                      out_tlast,
  input  logic                      out_tready,
  output logic [$clog2(N_IN)-1:0]   out_tid,
`ifdef STREAM_RR_ARBITER_STATS_EN
  output logic [N_IN*CNT_W-1:0]     pkt_cnt,
`endif
  output arb_state_e                dbg_state
);

  localparam int IDX_W = $clog2(N_IN);

  // Handshake: a beat moves on a port in any cycle where its valid and ready are both 1;
  // valid never waits for ready, and the output stage holds its beat until it is taken.

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic             tlast_q, tlast_d;
  logic [IDX_W-1:0] tid_q, tid_d;
  logic [NB-1:0]    data_q, data_d;

  logic [IDX_W-1:0] pick_idx;
  logic             any_req;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_ok;
  logic             can_load;
  logic             accept;
  logic             sel_last;
  logic [NB-1:0]    sel_data;

  rr_pick #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (in_tvalid),
    .last    (last_q),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // The owner is the only candidate while a packet is open; otherwise the pick applies at once.
  always_comb begin
    sel_idx   = (state_q == LOCK) ? owner_q : pick_idx;
    sel_ok    = (state_q == LOCK) | any_req;
    can_load  = ~valid_q | out_tready;
    accept    = sel_ok & can_load & in_tvalid[sel_idx];
    sel_last  = in_tlast[sel_idx];
    sel_data  = in_tdata[int'(sel_idx)*NB +: NB];
    in_tready = '0;
    in_tready[sel_idx] = sel_ok & can_load & aresetn;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    valid_d = valid_q;
    tlast_d = tlast_q;
    tid_d   = tid_q;
    data_d  = data_q;
    if (valid_q & out_tready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      valid_d = 1'b1;
      tlast_d = sel_last;
      tid_d   = sel_idx;
      data_d  = sel_data;
      if (sel_last) begin
        state_d = IDLE;
        last_d  = sel_idx;
      end else begin
        state_d = LOCK;
        owner_d = sel_idx;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_IN - 1);
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
      tid_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      tlast_q <= tlast_d;
      tid_q   <= tid_d;
      data_q  <= data_d;
    end
  end

  assign out_tdata  = data_q;
  assign out_tvalid = valid_q;
  assign out_tlast  = tlast_q;
  assign out_tid    = tid_q;
  assign dbg_state  = state_q;

`ifdef STREAM_RR_ARBITER_STATS_EN
  logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept & sel_last) begin
      cnt_d[sel_idx] = sat_inc(cnt_q[sel_idx]);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule
